// File: rtl/difftest_commit_queue_if.sv
// difftest_commit_queue_if
//   Bundles the commit-side and drain-side signals of the difftest commit queue.
//   slave  : view taken by the queue itself (consumes cm_*, produces out_*)
//   master : view taken by the core/drain environment driving the queue
//   Groups:
//     cm_*    retirement record from the core, cm_stall back-pressure
//     out_*   head record towards the reference-model drain, out_ready from it
//     count   occupancy, overflow sticky drop flag, ovf_clr to clear it
interface difftest_commit_queue_if #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             cm_valid;
    logic [31:0]      cm_pc;
    logic [31:0]      cm_inst;
    logic             cm_rd_we;
    logic [4:0]       cm_rd_addr;
    logic [31:0]      cm_rd_data;
    logic [3:0]       cm_mem_we;
    logic [15:0]      cm_mem_addr;
    logic [31:0]      cm_mem_wdata;
    logic             cm_stall;

    logic             out_valid;
    logic             out_ready;
    logic [SEQ_W-1:0] out_seq;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic             out_rd_we;
    logic [4:0]       out_rd_addr;
    logic [31:0]      out_rd_data;
    logic [3:0]       out_mem_we;
    logic [15:0]      out_mem_addr;
    logic [31:0]      out_mem_wdata;

    logic [CW-1:0]    count;
    logic             overflow;
    logic             ovf_clr;

    modport slave (
        input  cm_valid, cm_pc, cm_inst, cm_rd_we, cm_rd_addr, cm_rd_data,
               cm_mem_we, cm_mem_addr, cm_mem_wdata,
        output cm_stall,
        output out_valid, out_seq, out_pc, out_inst, out_rd_we, out_rd_addr,
               out_rd_data, out_mem_we, out_mem_addr, out_mem_wdata,
        input  out_ready,
        output count, overflow,
        input  ovf_clr
    );

    modport master (
        output cm_valid, cm_pc, cm_inst, cm_rd_we, cm_rd_addr, cm_rd_data,
               cm_mem_we, cm_mem_addr, cm_mem_wdata,
        input  cm_stall,
        input  out_valid, out_seq, out_pc, out_inst, out_rd_we, out_rd_addr,
               out_rd_data, out_mem_we, out_mem_addr, out_mem_wdata,
        output out_ready,
        input  count, overflow,
        output ovf_clr
    );
endinterface

// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue
//   Producer end of the difftest link. Each retired instruction is normalised,
//   stamped with a running sequence number and buffered in a DEPTH-entry FIFO,
//   then offered to the drain side over valid/ready.
//   Ports:
//     clk  core clock, rising edge
//     rst  asynchronous reset, active low
//     bus  difftest_commit_queue_if.slave (commit record in, head record out,
//          cm_stall, count, overflow, ovf_clr)
//   out_* fields read zero while the queue is empty. No input-to-output bypass:
//   a record pushed on one edge becomes the head only after that edge.
module difftest_commit_queue #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    difftest_commit_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             rd_we;
        logic [4:0]       rd_addr;
        logic [31:0]      rd_data;
        logic [3:0]       mem_we;
        logic [15:0]      mem_addr;
        logic [31:0]      mem_wdata;
    } rec_t;

    rec_t             mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [SEQ_W-1:0] seq_q;
    logic             ovf_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;
    rec_t new_rec;
    rec_t head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && bus.out_ready;
    // A full queue still accepts a commit when the head leaves in the same cycle.
    assign push  = bus.cm_valid && (!full || pop);
    assign drop  = bus.cm_valid && full && !pop;

    // Normalise the record so the drain never has to special-case x0 writes,
    // sub-word store addresses or stale store fields.
    always_comb begin
        new_rec           = '0;
        new_rec.seq       = seq_q;
        new_rec.pc        = bus.cm_pc;
        new_rec.inst      = bus.cm_inst;
        new_rec.rd_we     = bus.cm_rd_we && (bus.cm_rd_addr != 5'd0);
        new_rec.rd_addr   = bus.cm_rd_addr;
        new_rec.rd_data   = bus.cm_rd_data;
        new_rec.mem_we    = bus.cm_mem_we;
        if (bus.cm_mem_we != 4'd0) begin
            new_rec.mem_addr  = {bus.cm_mem_addr[15:2], 2'b00};
            new_rec.mem_wdata = bus.cm_mem_wdata;
        end
    end

    // Storage needs no reset: nothing reads it unless count_q says it is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq_q  <= seq_q + SEQ_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr];
        end
    end

    assign bus.out_valid     = !empty;
    assign bus.out_seq       = head.seq;
    assign bus.out_pc        = head.pc;
    assign bus.out_inst      = head.inst;
    assign bus.out_rd_we     = head.rd_we;
    assign bus.out_rd_addr   = head.rd_addr;
    assign bus.out_rd_data   = head.rd_data;
    assign bus.out_mem_we    = head.mem_we;
    assign bus.out_mem_addr  = head.mem_addr;
    assign bus.out_mem_wdata = head.mem_wdata;
    assign bus.cm_stall      = full;
    assign bus.count         = count_q;
    assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_difftest_commit_queue.sv
module tb_difftest_commit_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    difftest_commit_queue_if #(.DEPTH(8), .SEQ_W(32)) b8 ();
    difftest_commit_queue_if #(.DEPTH(8), .SEQ_W(4))  b4 ();

    difftest_commit_queue #(.DEPTH(8), .SEQ_W(32)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    difftest_commit_queue #(.DEPTH(8), .SEQ_W(4))  dut4 (.clk(clk), .rst(rst), .bus(b4));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cm8(input logic v, input logic [31:0] pc, input logic rd_we,
                       input logic [4:0] rd, input logic [31:0] rdd, input logic [3:0] mwe,
                       input logic [15:0] ma, input logic [31:0] md);
        b8.cm_valid     = v;
        b8.cm_pc        = pc;
        b8.cm_inst      = pc ^ 32'h0000_0013;
        b8.cm_rd_we     = rd_we;
        b8.cm_rd_addr   = rd;
        b8.cm_rd_data   = rdd;
        b8.cm_mem_we    = mwe;
        b8.cm_mem_addr  = ma;
        b8.cm_mem_wdata = md;
    endtask

    int          exp_head;
    int          pushed;
    int          cyc;
    int          qseq[$];
    logic [31:0] qpc[$];
    logic [31:0] pat;
    logic        pop_e;
    logic        push_e;
    logic        dropped_any;

    initial begin
        cm8(0, 0, 0, 0, 0, 0, 0, 0);
        b8.out_ready = 0;
        b8.ovf_clr   = 0;
        b4.cm_valid = 0; b4.cm_pc = 0; b4.cm_inst = 0; b4.cm_rd_we = 0; b4.cm_rd_addr = 0;
        b4.cm_rd_data = 0; b4.cm_mem_we = 0; b4.cm_mem_addr = 0; b4.cm_mem_wdata = 0;
        b4.out_ready = 0;
        b4.ovf_clr   = 0;

        // Reset values
        step(); step();
        chk("rst_count", b8.count, 0);
        chk("rst_valid", b8.out_valid, 0);
        chk("rst_stall", b8.cm_stall, 0);
        chk("rst_ovf", b8.overflow, 0);
        chk("rst_pc", b8.out_pc, 0);
        rst = 1;

        // Reset mid-stream with 3 entries
        for (int i = 0; i < 3; i++) begin
            cm8(1, 32'h50 + 32'(i * 4), 1, 5'd1, 32'(i), 0, 0, 0);
            step();
        end
        cm8(0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_count", b8.count, 3);
        #2 rst = 0;
        #1;
        chk("async_rst_count", b8.count, 0);
        chk("async_rst_valid", b8.out_valid, 0);
        step();
        rst = 1;

        // Single push into empty queue with out_ready already high
        cm8(1, 32'h0000_0100, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
        b8.out_ready = 1;
        step();
        cm8(0, 0, 0, 0, 0, 0, 0, 0);
        chk("s_valid", b8.out_valid, 1);
        chk("s_seq", b8.out_seq, 0);
        chk("s_pc", b8.out_pc, 32'h0000_0100);
        chk("s_inst", b8.out_inst, 32'h0000_0113);
        chk("s_rd_we", b8.out_rd_we, 1);
        chk("s_rd_addr", b8.out_rd_addr, 5);
        chk("s_rd_data", b8.out_rd_data, 32'hDEAD_BEEF);
        chk("s_count1", b8.count, 1);
        step();
        chk("s_count0", b8.count, 0);
        chk("s_valid0", b8.out_valid, 0);
        chk("s_pc0", b8.out_pc, 0);

        // Fill to 8, drop the 9th, drain in order (seq continues from 1)
        b8.out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            cm8(1, 32'h200 + 32'(i * 4), 0, 0, 0, 0, 0, 0);
            step();
        end
        chk("f_count8", b8.count, 8);
        chk("f_stall", b8.cm_stall, 1);
        chk("f_ovf0", b8.overflow, 0);
        cm8(1, 32'hBAD0, 0, 0, 0, 0, 0, 0);
        b8.ovf_clr = 1;
        step();
        chk("f_ovf_set_wins", b8.overflow, 1);
        chk("f_count_hold", b8.count, 8);
        chk("f_head_stable", b8.out_seq, 1);
        cm8(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("f_ovf_clr", b8.overflow, 0);
        b8.ovf_clr   = 0;
        b8.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("d_seq", b8.out_seq, 64'(1 + i));
            chk("d_pc", b8.out_pc, 64'(32'h200 + 32'(i * 4)));
            step();
        end
        chk("d_count0", b8.count, 0);

        // Full queue with simultaneous push and pop for 20 cycles
        b8.out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            cm8(1, 32'h300 + 32'(i * 4), 0, 0, 0, 0, 0, 0);
            step();
        end
        exp_head = 9;
        b8.out_ready = 1;
        for (int k = 0; k < 20; k++) begin
            cm8(1, 32'h400 + 32'(k * 4), 0, 0, 0, 0, 0, 0);
            step();
            exp_head++;
            chk("pp_count", b8.count, 8);
            chk("pp_ovf", b8.overflow, 0);
            chk("pp_seq", b8.out_seq, 64'(exp_head));
        end
        cm8(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("pp_drain_seq", b8.out_seq, 64'(exp_head + i));
            step();
        end
        chk("pp_empty", b8.out_valid, 0);

        // Normalisation of x0 writes and store fields
        b8.out_ready = 0;
        cm8(1, 32'h600, 1, 5'd0, 32'h55, 4'd0, 16'h1237, 32'hAAAA);
        step();
        cm8(1, 32'h604, 0, 5'd3, 0, 4'b0100, 16'h1236, 32'h00CC_0000);
        step();
        cm8(0, 0, 0, 0, 0, 0, 0, 0);
        chk("n_count2", b8.count, 2);
        chk("n_rd_we_x0", b8.out_rd_we, 0);
        chk("n_rd_data", b8.out_rd_data, 32'h55);
        chk("n_nostore_addr", b8.out_mem_addr, 0);
        chk("n_nostore_data", b8.out_mem_wdata, 0);
        b8.out_ready = 1;
        step();
        chk("n_st_addr", b8.out_mem_addr, 16'h1234);
        chk("n_st_we", b8.out_mem_we, 4'b0100);
        chk("n_st_data", b8.out_mem_wdata, 32'h00CC_0000);
        chk("n_st_seq", b8.out_seq, 64'(exp_head + 9));
        step();
        chk("n_count0", b8.count, 0);

        // SEQ_W=4 instance: 20 pushes against a scoreboard, irregular out_ready
        pat = 32'hF0F0_0301;
        pushed = 0;
        cyc = 0;
        dropped_any = 0;
        while ((pushed < 20 || qseq.size() != 0) && cyc < 300) begin
            b4.cm_valid  = (pushed < 20);
            b4.cm_pc     = 32'h1000 + 32'(pushed * 4);
            b4.out_ready = pat[cyc % 32];
            chk("w_valid", b4.out_valid, 64'(qseq.size() != 0));
            chk("w_stall", b4.cm_stall, 64'(qseq.size() == 8));
            chk("w_count", b4.count, 64'(qseq.size()));
            if (qseq.size() != 0) begin
                chk("w_seq", b4.out_seq, 64'(qseq[0]));
                chk("w_pc", b4.out_pc, 64'(qpc[0]));
            end
            pop_e  = (qseq.size() != 0) && b4.out_ready;
            push_e = b4.cm_valid && (qseq.size() < 8 || pop_e);
            if (b4.cm_valid && !push_e) dropped_any = 1;
            step();
            if (pop_e) begin
                void'(qseq.pop_front());
                void'(qpc.pop_front());
            end
            if (push_e) begin
                qseq.push_back(pushed % 16);
                qpc.push_back(32'h1000 + 32'(pushed * 4));
                pushed++;
            end
            cyc++;
        end
        b4.cm_valid  = 0;
        b4.out_ready = 0;
        chk("w_done_in_budget", 64'(cyc < 300), 1);
        chk("w_ovf", b4.overflow, 64'(dropped_any));
        chk("w_empty", b4.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
